// File: rtl/core_alu_wb.sv
`default_nettype none
// core_alu_wb: ALU issue/writeback controller for the EMC08 8-bit core (8051-style ACC/B/PSW writeback).
// Optional macro CORE_ALU_MULDIV_STALL_EN holds MUL/DIV in EXEC for 4 cycles instead of 1.
module core_alu_wb (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [4:0]  opcode_i,
  input  logic [7:0]  operand1_i,
  input  logic [7:0]  operand2_i,
  input  logic        wr_acc_i,
  input  logic        acc_we_i,
  input  logic [7:0]  acc_wdata_i,
  input  logic        b_we_i,
  input  logic [7:0]  b_wdata_i,
  output logic        alu_en_o,
  output logic [4:0]  alu_opcode_o,
  output logic [7:0]  alu_operand1_o,
  output logic [7:0]  alu_operand2_o,
  output logic        alu_cy_o,
  output logic        alu_ac_o,
  output logic        alu_ov_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_cy_i,
  input  logic        alu_ac_i,
  input  logic        alu_ov_i,
  output logic [7:0]  acc_o,
  output logic [7:0]  b_o,
  output logic        cy_o,
  output logic        ac_o,
  output logic        ov_o,
  output logic        p_o,
  output logic [7:0]  res_o,
  output logic        cmp_eq_o,
  output logic        busy_o,
  output logic        done_o
);

  // Encodings follow the ALU_* codes of the core's instruction-set header.
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDC = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_INC  = 5'd3;
  localparam logic [4:0] ALU_DEC  = 5'd4;
  localparam logic [4:0] ALU_MUL  = 5'd5;
  localparam logic [4:0] ALU_DIV  = 5'd6;
  localparam logic [4:0] ALU_DA   = 5'd7;
  localparam logic [4:0] ALU_CPL  = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_OR   = 5'd10;
  localparam logic [4:0] ALU_XOR  = 5'd11;
  localparam logic [4:0] ALU_RL   = 5'd12;
  localparam logic [4:0] ALU_RLC  = 5'd13;
  localparam logic [4:0] ALU_RR   = 5'd14;
  localparam logic [4:0] ALU_RRC  = 5'd15;
  localparam logic [4:0] ALU_SWAP = 5'd16;
  localparam logic [4:0] ALU_COMP = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   wr_acc_q;
  logic   exec_last;

`ifdef CORE_ALU_MULDIV_STALL_EN
  logic [1:0] stall_cnt;
  logic       is_muldiv;

  assign is_muldiv = (alu_opcode_o == ALU_MUL) || (alu_opcode_o == ALU_DIV);
  assign exec_last = !is_muldiv || (stall_cnt == 2'd3);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      stall_cnt <= 2'd0;
    else if (state == S_EXEC && !exec_last)
      stall_cnt <= stall_cnt + 2'd1;
    else
      stall_cnt <= 2'd0;
  end
`else
  assign exec_last = 1'b1;
`endif

  assign alu_cy_o = cy_o;
  assign alu_ac_o = ac_o;
  assign alu_ov_o = ov_o;
  assign p_o      = ^acc_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      wr_acc_q       <= 1'b0;
      alu_en_o       <= 1'b0;
      alu_opcode_o   <= 5'd0;
      alu_operand1_o <= 8'd0;
      alu_operand2_o <= 8'd0;
      acc_o          <= 8'd0;
      b_o            <= 8'd0;
      cy_o           <= 1'b0;
      ac_o           <= 1'b0;
      ov_o           <= 1'b0;
      res_o          <= 8'd0;
      cmp_eq_o       <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc_we_i) acc_o <= acc_wdata_i;
          if (b_we_i)   b_o   <= b_wdata_i;
          if (req_i) begin
            alu_opcode_o   <= opcode_i;
            alu_operand1_o <= operand1_i;
            alu_operand2_o <= operand2_i;
            wr_acc_q       <= wr_acc_i;
            alu_en_o       <= 1'b1;
            busy_o         <= 1'b1;
            state          <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_last) begin
            alu_en_o <= 1'b0;
            done_o   <= 1'b1;
            state    <= S_DONE;
            case (alu_opcode_o)
              ALU_ADD, ALU_ADDC, ALU_SUB, ALU_INC, ALU_DEC, ALU_DA, ALU_RR, ALU_RRC,
              ALU_RL, ALU_RLC, ALU_OR, ALU_AND, ALU_XOR, ALU_SWAP, ALU_CPL: begin
                res_o <= alu_result_i[7:0];
                if (wr_acc_q) acc_o <= alu_result_i[7:0];
                cy_o <= alu_cy_i;
                ac_o <= alu_ac_i;
                ov_o <= alu_ov_i;
              end
              ALU_COMP: begin
                cmp_eq_o <= alu_result_i[0];
                cy_o     <= alu_cy_i;
              end
              ALU_MUL: begin
                acc_o <= alu_result_i[7:0];
                b_o   <= alu_result_i[15:8];
                cy_o  <= 1'b0;
                ac_o  <= 1'b0;
                ov_o  <= alu_ov_i;
              end
              ALU_DIV: begin
                cy_o <= 1'b0;
                ac_o <= 1'b0;
                // Divide by zero leaves ACC/B intact and only raises OV.
                if (alu_operand2_o == 8'd0) begin
                  ov_o <= 1'b1;
                end else begin
                  acc_o <= alu_result_i[15:8];
                  b_o   <= alu_result_i[7:0];
                  ov_o  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          alu_en_o <= 1'b0;
          busy_o   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_alu_wb.sv
`default_nettype none
// tb_core_alu_wb: self-checking bench for core_alu_wb with a behavioural 8051-style ALU and reference model.
module tb_core_alu_wb;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDC = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_INC  = 5'd3;
  localparam logic [4:0] ALU_DEC  = 5'd4;
  localparam logic [4:0] ALU_MUL  = 5'd5;
  localparam logic [4:0] ALU_DIV  = 5'd6;
  localparam logic [4:0] ALU_DA   = 5'd7;
  localparam logic [4:0] ALU_CPL  = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_OR   = 5'd10;
  localparam logic [4:0] ALU_XOR  = 5'd11;
  localparam logic [4:0] ALU_RL   = 5'd12;
  localparam logic [4:0] ALU_RLC  = 5'd13;
  localparam logic [4:0] ALU_RR   = 5'd14;
  localparam logic [4:0] ALU_RRC  = 5'd15;
  localparam logic [4:0] ALU_SWAP = 5'd16;
  localparam logic [4:0] ALU_COMP = 5'd17;

  typedef struct packed {
    logic [15:0] res;
    logic        cy;
    logic        ac;
    logic        ov;
  } alu_t;

  logic clk, rst_n, req, wr_acc, acc_we, b_we;
  logic [4:0]  opcode;
  logic [7:0]  operand1, operand2, acc_wdata, b_wdata;
  logic        alu_en, alu_cy, alu_ac, alu_ov;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_operand1, alu_operand2;
  logic [7:0]  acc, b, res;
  logic        cy, ac, ov, p, cmp_eq, busy, done;
  alu_t        alu_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_acc, m_b, m_res;
  logic       m_cy, m_ac, m_ov, m_eq;

  core_alu_wb dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .opcode_i(opcode),
    .operand1_i(operand1), .operand2_i(operand2), .wr_acc_i(wr_acc),
    .acc_we_i(acc_we), .acc_wdata_i(acc_wdata), .b_we_i(b_we), .b_wdata_i(b_wdata),
    .alu_en_o(alu_en), .alu_opcode_o(alu_opcode), .alu_operand1_o(alu_operand1),
    .alu_operand2_o(alu_operand2), .alu_cy_o(alu_cy), .alu_ac_o(alu_ac), .alu_ov_o(alu_ov),
    .alu_result_i(alu_out.res), .alu_cy_i(alu_out.cy), .alu_ac_i(alu_out.ac), .alu_ov_i(alu_out.ov),
    .acc_o(acc), .b_o(b), .cy_o(cy), .ac_o(ac), .ov_o(ov), .p_o(p), .res_o(res),
    .cmp_eq_o(cmp_eq), .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sgn(input logic [7:0] v);
    return (v < 8'd128) ? int'(v) : int'(v) - 256;
  endfunction

  // Combinational 8051-style ALU standing in for core_alu.
  function automatic alu_t alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] bb,
                                 input logic c, input logic h, input logic o);
    alu_t r;
    int s, ci, sd;
    r.res = 16'h0; r.cy = c; r.ac = h; r.ov = o;
    ci = int'(c);
    case (op)
      ALU_ADD, ALU_ADDC: begin
        if (op == ALU_ADD) ci = 0;
        s = int'(a) + int'(bb) + ci;
        sd = sgn(a) + sgn(bb) + ci;
        r.res = 16'(s % 256); r.cy = (s > 255);
        r.ac = ((int'(a) % 16) + (int'(bb) % 16) + ci) > 15;
        r.ov = (sd > 127) || (sd < -128);
      end
      ALU_SUB: begin
        s = int'(a) - int'(bb) - ci;
        sd = sgn(a) - sgn(bb) - ci;
        r.res = 16'((s + 256) % 256); r.cy = (s < 0);
        r.ac = ((int'(a) % 16) - (int'(bb) % 16) - ci) < 0;
        r.ov = (sd > 127) || (sd < -128);
      end
      ALU_INC:  r.res = 16'((int'(a) + 1) % 256);
      ALU_DEC:  r.res = 16'((int'(a) + 255) % 256);
      ALU_DA: begin
        s = int'(a);
        if ((s % 16) > 9 || h) begin s = s + 6; if (s > 255) r.cy = 1'b1; s = s % 256; end
        if ((s / 16) > 9 || r.cy) begin s = s + 96; if (s > 255) r.cy = 1'b1; s = s % 256; end
        r.res = 16'(s);
      end
      ALU_CPL:  r.res = 16'(255 - int'(a));
      ALU_AND:  r.res = {8'h0, a & bb};
      ALU_OR:   r.res = {8'h0, a | bb};
      ALU_XOR:  r.res = {8'h0, a ^ bb};
      ALU_RL:   r.res = 16'((int'(a) * 2) % 256 + int'(a) / 128);
      ALU_RR:   r.res = 16'(int'(a) / 2 + (int'(a) % 2) * 128);
      ALU_RLC:  begin r.res = 16'((int'(a) * 2) % 256 + ci); r.cy = a[7]; end
      ALU_RRC:  begin r.res = 16'(int'(a) / 2 + ci * 128); r.cy = a[0]; end
      ALU_SWAP: r.res = 16'((int'(a) % 16) * 16 + int'(a) / 16);
      ALU_COMP: begin r.res = {15'h0, a == bb}; r.cy = (a < bb); end
      ALU_MUL:  begin s = int'(a) * int'(bb); r.res = 16'(s); r.cy = 1'b0; r.ov = (s > 255); end
      ALU_DIV: begin
        r.cy = 1'b0;
        if (bb == 8'd0) r.ov = 1'b1;
        else begin r.res = {a / bb, a % bb}; r.ov = 1'b0; end
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb alu_out = alu_f(alu_opcode, alu_operand1, alu_operand2, alu_cy, alu_ac, alu_ov);

  function automatic int n_of(input logic [4:0] op);
`ifdef CORE_ALU_MULDIV_STALL_EN
    return (op == ALU_MUL || op == ALU_DIV) ? 4 : 1;
`else
    return (op == ALU_MUL) ? 1 : 1;
`endif
  endfunction

  // Reference model: architectural effect of one completed operation.
  task automatic model_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] bb, input logic wr);
    alu_t r;
    int pr;
    r = alu_f(op, a, bb, m_cy, m_ac, m_ov);
    if (op inside {ALU_ADD, ALU_ADDC, ALU_SUB, ALU_INC, ALU_DEC, ALU_DA, ALU_RR, ALU_RRC,
                   ALU_RL, ALU_RLC, ALU_OR, ALU_AND, ALU_XOR, ALU_SWAP, ALU_CPL}) begin
      m_res = r.res[7:0];
      if (wr) m_acc = r.res[7:0];
      m_cy = r.cy; m_ac = r.ac; m_ov = r.ov;
    end else if (op == ALU_COMP) begin
      m_eq = (a == bb); m_cy = (a < bb);
    end else if (op == ALU_MUL) begin
      pr = int'(a) * int'(bb);
      m_acc = 8'(pr % 256); m_b = 8'(pr / 256);
      m_cy = 1'b0; m_ac = 1'b0; m_ov = (pr > 255);
    end else if (op == ALU_DIV) begin
      m_cy = 1'b0; m_ac = 1'b0;
      if (bb == 8'd0) m_ov = 1'b1;
      else begin m_acc = a / bb; m_b = a % bb; m_ov = 1'b0; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_acc"}, 32'(acc), 32'(m_acc));
    check({tag, "_b"},   32'(b),   32'(m_b));
    check({tag, "_cy"},  32'(cy),  32'(m_cy));
    check({tag, "_ac"},  32'(ac),  32'(m_ac));
    check({tag, "_ov"},  32'(ov),  32'(m_ov));
    check({tag, "_p"},   32'(p),   32'(^m_acc));
    check({tag, "_res"}, 32'(res), 32'(m_res));
    check({tag, "_eq"},  32'(cmp_eq), 32'(m_eq));
    check({tag, "_alucy"}, 32'(alu_cy), 32'(m_cy));
  endtask

  task automatic do_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] bb, input logic wr,
                       input logic jam, input logic ld, input logic [7:0] ld_val);
    int lat;
    @(negedge clk);
    req = 1'b1; opcode = op; operand1 = a; operand2 = bb; wr_acc = wr;
    acc_we = ld; acc_wdata = ld_val;
    @(posedge clk); #1;
    if (ld) m_acc = ld_val;
    model_op(op, a, bb, wr);
    check("busy_rise", 32'(busy), 32'd1);
    check("alu_en", 32'(alu_en), 32'd1);
    check("alu_opnds", {11'h0, alu_opcode, alu_operand1, alu_operand2}, {11'h0, op, a, bb});
    if (jam) begin
      req = 1'b1; opcode = ALU_CPL; operand1 = ~a; wr_acc = 1'b1;
      acc_we = 1'b1; acc_wdata = 8'h5A; b_we = 1'b1; b_wdata = 8'hA5;
    end else begin
      req = 1'b0; acc_we = 1'b0;
    end
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0; acc_we = 1'b0; b_we = 1'b0;
    check("latency", 32'(lat), 32'(n_of(op)));
    check("en_off", 32'(alu_en), 32'd0);
    check_regs("wb");
    @(posedge clk); #1;
    check("done_fall", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic load_direct(input logic wa, input logic [7:0] va, input logic wb, input logic [7:0] vb);
    @(negedge clk);
    acc_we = wa; acc_wdata = va; b_we = wb; b_wdata = vb;
    @(posedge clk); #1;
    acc_we = 1'b0; b_we = 1'b0;
    if (wa) m_acc = va;
    if (wb) m_b = vb;
    check("ld_acc", 32'(acc), 32'(m_acc));
    check("ld_b", 32'(b), 32'(m_b));
  endtask

  task automatic model_reset();
    m_acc = 8'h0; m_b = 8'h0; m_res = 8'h0;
    m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0; m_eq = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regs"}, {8'h0, acc, b, res}, 32'h0);
    check({tag, "_flags"}, {24'h0, cy, ac, ov, p, cmp_eq, busy, done, alu_en}, 32'h0);
    check({tag, "_alu"}, {11'h0, alu_opcode, alu_operand1, alu_operand2}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] op;
    logic [7:0] a, bb;
    rst_n = 1'b0; req = 1'b0; opcode = 5'd0; operand1 = 8'h0; operand2 = 8'h0; wr_acc = 1'b0;
    acc_we = 1'b0; acc_wdata = 8'h0; b_we = 1'b0; b_wdata = 8'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // ADD FF+01 sets CY so the following ADDC sees a carry-in.
    do_op(ALU_ADD, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h0);
    check("add_cy", 32'(cy), 32'd1);
    do_op(ALU_ADDC, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0);
    check("addc_acc", 32'(acc), 32'h80);
    check("addc_flags", {28'h0, cy, ac, ov, p}, {28'h0, 4'b0111});

    do_op(ALU_MUL, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h0);
    check("mul_ab", {16'h0, acc, b}, 32'h0002);
    check("mul_ovcy", {30'h0, ov, cy}, 32'h2);

    load_direct(1'b1, 8'h11, 1'b1, 8'h22);
    do_op(ALU_DIV, 8'hFB, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0);
    check("div0_ab", {16'h0, acc, b}, 32'h1122);
    check("div0_ovcy", {30'h0, ov, cy}, 32'h2);
    do_op(ALU_DIV, 8'hFB, 8'h12, 1'b1, 1'b0, 1'b0, 8'h0);
    check("div_ab", {16'h0, acc, b}, 32'h0D11);
    check("div_ov", 32'(ov), 32'd0);

    load_direct(1'b1, 8'h33, 1'b0, 8'h0);
    do_op(ALU_COMP, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0, 8'h0);
    check("comp_lt", {23'h0, acc, cy, cmp_eq}, {23'h0, 8'h33, 2'b10});
    do_op(ALU_COMP, 8'h09, 8'h09, 1'b1, 1'b0, 1'b0, 8'h0);
    check("comp_eq", 32'(cmp_eq), 32'd1);

    // Requests and direct loads while busy must be dropped.
    do_op(ALU_XOR, 8'h3C, 8'h0F, 1'b1, 1'b1, 1'b0, 8'h0);
    do_op(ALU_MUL, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h0);
    // Same-cycle direct load: writeback wins when wr_acc=1, direct load stays when wr_acc=0.
    do_op(ALU_INC, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99);
    do_op(ALU_INC, 8'h41, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99);
    do_op(5'd25, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 8'h0);

    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 20));
      a  = 8'($urandom);
      bb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 5) == 0)
        load_direct(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      do_op(op, a, bb, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            8'($urandom));
    end

    // Reset in the middle of a MUL: immediate clear and no later writeback.
    load_direct(1'b1, 8'h77, 1'b1, 8'h66);
    @(negedge clk);
    req = 1'b1; opcode = ALU_MUL; operand1 = 8'h10; operand2 = 8'h20; wr_acc = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_all_zero("rst_after");
    do_op(ALU_ADD, 8'h21, 8'h12, 1'b1, 1'b0, 1'b0, 8'h0);
    check("post_rst_acc", 32'(acc), 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
